// File: rtl/vecchk_pkg.sv
// Shared types and width helpers for the exhaustive vector checker.
package vecchk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // err_count must reach 2^n_in without wrapping, hence one extra bit
    function automatic int unsigned err_width(input int unsigned n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/exhaustive_vector_checker_if.sv
// Stimulus/response and result bundle between the checker and the logic under test.
interface exhaustive_vector_checker_if #(
    parameter int unsigned N_IN = 3
);
    import vecchk_pkg::*;

    logic                          start;
    logic                          dut_in;
    logic [N_IN-1:0]               vec_out;
    logic                          busy;
    logic                          done;
    logic                          pass;
    logic [err_width(N_IN)-1:0]    err_count;
    logic [N_IN-1:0]               first_fail_idx;
    logic                          first_fail_valid;

    modport master (
        input  start, dut_in,
        output vec_out, busy, done, pass, err_count, first_fail_idx, first_fail_valid
    );

    modport slave (
        output start, dut_in,
        input  vec_out, busy, done, pass, err_count, first_fail_idx, first_fail_valid
    );

endinterface

// File: rtl/exhaustive_vector_checker_settle_timer.sv
// SETTLE-cycle modulo counter; sample_tick marks the last held cycle of a vector.
module settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic sample_tick
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST_CNT) cnt <= '0;
            else                 cnt <= cnt + CW'(1);
        end
    end

    assign sample_tick = enable && (cnt == LAST_CNT);

endmodule

// File: rtl/exhaustive_vector_checker.sv
// Walks all 2^N_IN input vectors, compares responses against TRUTH, reports results.
module exhaustive_vector_checker
    import vecchk_pkg::*;
#(
    parameter int unsigned             N_IN   = 3,
    parameter int unsigned             SETTLE = 2,
    parameter logic [(2**N_IN)-1:0]    TRUTH  = 8'hE8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    exhaustive_vector_checker_if.master   bus
);

    localparam int unsigned     EW   = err_width(N_IN);
    localparam logic [N_IN-1:0] LAST = '1;

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx;
    logic [EW-1:0]   err_count;
    logic [N_IN-1:0] ff_idx;
    logic            ff_valid;
    logic            start_run;
    logic            sample_tick;
    logic            mismatch;

    assign start_run = bus.start && (state != ST_RUN);
    // 4-state compare so an X/Z response is reported as a failure
    assign mismatch  = (bus.dut_in !== TRUTH[idx]);

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (start_run),
        .enable      (state == ST_RUN),
        .sample_tick (sample_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:           if (sample_tick && idx == LAST) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            err_count <= '0;
            ff_idx    <= '0;
            ff_valid  <= 1'b0;
        end else if (start_run) begin
            idx       <= '0;
            err_count <= '0;
            ff_idx    <= '0;
            ff_valid  <= 1'b0;
        end else if (state == ST_RUN && sample_tick) begin
            if (mismatch) begin
                err_count <= err_count + EW'(1);
                if (!ff_valid) begin
                    ff_idx   <= idx;
                    ff_valid <= 1'b1;
                end
            end
            if (idx != LAST) idx <= idx + N_IN'(1);
        end
    end

    // Flags decode the state register directly; pass qualifies the final count
    always_comb begin
        bus.busy             = (state == ST_RUN);
        bus.done             = (state == ST_DONE);
        bus.pass             = (state == ST_DONE) && (err_count == '0);
        bus.vec_out          = idx;
        bus.err_count        = err_count;
        bus.first_fail_idx   = ff_idx;
        bus.first_fail_valid = ff_valid;
    end

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Directed and randomized runs of two checker configurations against a truth-table model.
module tb_exhaustive_vector_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exhaustive_vector_checker_if #(.N_IN(3)) a_if ();
    exhaustive_vector_checker_if #(.N_IN(4)) b_if ();

    exhaustive_vector_checker #(.N_IN(3), .SETTLE(2), .TRUTH(8'hE8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    exhaustive_vector_checker #(.N_IN(4), .SETTLE(1), .TRUTH(16'h8000)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    int   checks = 0;
    int   errors = 0;
    int   mode_a = 0;
    int   mode_b = 4;
    bit   x_inj  = 1'b0;
    logic x_val  = 1'b0;
    bit   rnd_tbl [16];

    // Modes: 0 majority, 1 stuck-0, 2 inverted majority, 3 random table, 4 AND4, 5 OR4
    function automatic logic resp(input int mode, input int k);
        case (mode)
            0: begin
                if (x_inj && k == 2) return x_val;
                return logic'($countones(k) >= 2);
            end
            1:       return 1'b0;
            2:       return logic'($countones(k) < 2);
            3:       return logic'(rnd_tbl[k]);
            4:       return logic'(k == 15);
            5:       return logic'(k != 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic truth(input bit sel, input int k);
        if (sel) return logic'(k == 15);
        return logic'($countones(k) >= 2);
    endfunction

    always_comb a_if.dut_in = resp(mode_a, int'(a_if.vec_out));
    always_comb b_if.dut_in = resp(mode_b, int'(b_if.vec_out));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) b_if.start = v;
        else     a_if.start = v;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_vec"},  32'(a_if.vec_out), 0);
        chk({tag, "_busy"}, 32'(a_if.busy), 0);
        chk({tag, "_done"}, 32'(a_if.done), 0);
        chk({tag, "_pass"}, 32'(a_if.pass), 0);
        chk({tag, "_err"},  32'(a_if.err_count), 0);
        chk({tag, "_ffi"},  32'(a_if.first_fail_idx), 0);
        chk({tag, "_ffv"},  32'(a_if.first_fail_valid), 0);
    endtask

    // One run: start is seen at E0; iteration j samples just after edge E0+j
    task automatic run(input bit sel, input int mode, input int restart_j, input int abort_j);
        int nv, st, exp_err, exp_ff;
        bit exp_ffv;
        logic [31:0] vec, err, ffi;
        logic busy, done, pass, ffv;
        nv = sel ? 16 : 8;
        st = sel ? 1 : 2;
        if (sel) mode_b = mode;
        else     mode_a = mode;
        exp_err = 0; exp_ff = 0; exp_ffv = 1'b0;
        for (int k = 0; k < nv; k++) begin
            if (resp(mode, k) !== truth(sel, k)) begin
                exp_err++;
                if (!exp_ffv) begin exp_ffv = 1'b1; exp_ff = k; end
            end
        end
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        for (int j = 0; j <= nv * st; j++) begin
            @(negedge clk);
            set_start(sel, logic'(j == restart_j));
            vec  = sel ? 32'(b_if.vec_out) : 32'(a_if.vec_out);
            err  = sel ? 32'(b_if.err_count) : 32'(a_if.err_count);
            ffi  = sel ? 32'(b_if.first_fail_idx) : 32'(a_if.first_fail_idx);
            busy = sel ? b_if.busy : a_if.busy;
            done = sel ? b_if.done : a_if.done;
            pass = sel ? b_if.pass : a_if.pass;
            ffv  = sel ? b_if.first_fail_valid : a_if.first_fail_valid;
            if (j < nv * st) begin
                chk("run_vec",  vec, 32'(j / st));
                chk("run_busy", 32'(busy), 1);
                chk("run_done", 32'(done), 0);
                if (j == 0) begin
                    chk("clr_err",  err, 0);
                    chk("clr_ffv",  32'(ffv), 0);
                    chk("clr_pass", 32'(pass), 0);
                end
            end else begin
                chk("end_done", 32'(done), 1);
                chk("end_busy", 32'(busy), 0);
                chk("end_vec",  vec, 32'(nv - 1));
                chk("end_err",  err, 32'(exp_err));
                chk("end_ffv",  32'(ffv), 32'(exp_ffv));
                chk("end_ffi",  ffi, 32'(exp_ff));
                chk("end_pass", 32'(pass), 32'(exp_err == 0));
            end
            if (j == abort_j) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                #1 chk_reset("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        repeat (3) @(negedge clk);
        chk("hold_done", 32'(sel ? b_if.done : a_if.done), 1);
        chk("hold_err",  32'(sel ? b_if.err_count : a_if.err_count), 32'(exp_err));
    endtask

    initial begin
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        #12;
        chk_reset("reset");
        chk("reset_b_done", 32'(b_if.done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 0, -1, -1);   // correct majority
        run(1'b0, 1, -1, -1);   // stuck-at-0 response
        run(1'b0, 2, -1, -1);   // inverted majority
        run(1'b0, 2, -1, -1);   // rerun must clear and reproduce
        run(1'b0, 0, -1, 6);    // reset asserted at E0+7
        run(1'b0, 0, -1, -1);   // clean run after abort
        run(1'b0, 0, 4, -1);    // start again at E0+5 is ignored
        x_inj = 1'b1;
        x_val = 1'bx;
        run(1'b0, 0, -1, -1);   // unknown response on vector 2
        x_inj = 1'b0;
        run(1'b1, 4, -1, -1);   // AND4 against its own table
        run(1'b1, 5, -1, -1);   // OR4 against the AND4 table

        repeat (3) begin
            foreach (rnd_tbl[i]) rnd_tbl[i] = bit'($urandom_range(0, 1));
            run(1'b0, 3, -1, -1);
            run(1'b1, 3, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
